// File: rtl/sent_rx_crc_arbiter.sv
// sent_rx_crc_arbiter
// Shares one SENT CRC checker among the five frame-data producers
// (fast6, fast4, fast3, short serial, enhanced serial). Each source has a
// one-deep pending buffer; sources are granted round-robin. The arbiter
// runs the start/done handshake with a timeout and reports each verdict
// on a single result port.
module sent_rx_crc_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_rx,
    input  logic        reset,
    input  logic [4:0]  req,
    input  logic [27:0] data_fast6,
    input  logic [19:0] data_fast4,
    input  logic [15:0] data_fast3,
    input  logic [15:0] data_short,
    input  logic [27:0] data_enhanced,
    input  logic        ovr_clr,
    output logic        crc_start,
    output logic [27:0] crc_data,
    output logic [2:0]  crc_mode,
    input  logic        crc_done,
    input  logic        crc_ok,
    output logic        out_valid,
    output logic [2:0]  out_src,
    output logic [27:0] out_data,
    output logic        out_crc_ok,
    output logic        out_timeout,
    output logic [4:0]  overrun,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    // Last WAIT count value before the timeout fires. WAIT is entered with
    // the counter at 0, so the forced result lands TIMEOUT+1 cycles after
    // crc_start drops.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT);

    state_t      state_q;
    logic [4:0]  pend_q;
    logic [4:0]  pend_d;
    logic [4:0]  overrun_q;
    logic [4:0]  overrun_d;
    logic [4:0]  ovr_new_s;
    logic [4:0]  grant_oh_s;
    logic [27:0] word_q [5];
    logic [27:0] in_word_s [5];
    logic [2:0]  rr_q;
    logic [2:0]  rr_next_s;
    logic [2:0]  sel_idx_s;
    logic        sel_found_s;
    logic        grant_s;
    logic [7:0]  cnt_q;

    logic        crc_start_q;
    logic [27:0] crc_data_q;
    logic [2:0]  crc_mode_q;
    logic        out_valid_q;
    logic [2:0]  out_src_q;
    logic [27:0] out_data_q;
    logic        out_crc_ok_q;
    logic        out_timeout_q;
    logic        busy_q;

    // Round-robin pick: first set pending bit searching upward from start,
    // wrapping modulo 5. Returns {found, index}.
    function automatic logic [3:0] rr_pick(input logic [4:0] pend, input logic [2:0] start);
        logic [3:0] pos;
        logic [2:0] cand;
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 5; k++) begin
            pos  = {1'b0, start} + 4'(k);
            cand = (pos >= 4'd5) ? 3'(pos - 4'd5) : pos[2:0];
            if (!found && pend[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Source words zero-extended to the checker width.
    assign in_word_s[0] = data_fast6;
    assign in_word_s[1] = {8'd0, data_fast4};
    assign in_word_s[2] = {12'd0, data_fast3};
    assign in_word_s[3] = {12'd0, data_short};
    assign in_word_s[4] = data_enhanced;

    assign {sel_found_s, sel_idx_s} = rr_pick(pend_q, rr_q);
    assign grant_s    = (state_q == S_IDLE) && sel_found_s;
    assign grant_oh_s = grant_s ? (5'd1 << sel_idx_s) : 5'd0;
    assign rr_next_s  = (sel_idx_s == 3'd4) ? 3'd0 : sel_idx_s + 3'd1;

    // A request landing on the cycle its source is granted refills the
    // buffer without counting as an overrun; a new overrun beats ovr_clr.
    assign ovr_new_s = req & pend_q & ~grant_oh_s;
    assign pend_d    = (pend_q & ~grant_oh_s) | req;
    assign overrun_d = (ovr_clr ? 5'd0 : overrun_q) | ovr_new_s;

    // Per-source pending buffers and sticky overrun flags.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            pend_q    <= 5'd0;
            overrun_q <= 5'd0;
            for (int i = 0; i < 5; i++) begin
                word_q[i] <= 28'd0;
            end
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            for (int i = 0; i < 5; i++) begin
                if (req[i]) begin
                    word_q[i] <= in_word_s[i];
                end else begin
                    word_q[i] <= word_q[i];
                end
            end
        end
    end

    // Grant/handshake/report sequencer with registered checker and result outputs.
    always_ff @(posedge clk_rx or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rr_q          <= 3'd0;
            cnt_q         <= 8'd0;
            crc_start_q   <= 1'b0;
            crc_data_q    <= 28'd0;
            crc_mode_q    <= 3'd0;
            out_valid_q   <= 1'b0;
            out_src_q     <= 3'd0;
            out_data_q    <= 28'd0;
            out_crc_ok_q  <= 1'b0;
            out_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_valid_q <= 1'b0;
                    if (grant_s) begin
                        crc_data_q  <= word_q[sel_idx_s];
                        crc_mode_q  <= sel_idx_s;
                        rr_q        <= rr_next_s;
                        crc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_GRANT;
                    end else begin
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    crc_start_q <= 1'b0;
                    cnt_q       <= 8'd0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (crc_done) begin
                        out_valid_q   <= 1'b1;
                        out_src_q     <= crc_mode_q;
                        out_data_q    <= crc_data_q;
                        out_crc_ok_q  <= crc_ok;
                        out_timeout_q <= 1'b0;
                        state_q       <= S_REPORT;
                    end else if (cnt_q == TMO_LAST) begin
                        out_valid_q   <= 1'b1;
                        out_src_q     <= crc_mode_q;
                        out_data_q    <= crc_data_q;
                        out_crc_ok_q  <= 1'b0;
                        out_timeout_q <= 1'b1;
                        state_q       <= S_REPORT;
                    end else begin
                        cnt_q         <= cnt_q + 8'd1;
                        state_q       <= S_WAIT;
                    end
                end
                S_REPORT: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    crc_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign crc_start   = crc_start_q;
    assign crc_data    = crc_data_q;
    assign crc_mode    = crc_mode_q;
    assign out_valid   = out_valid_q;
    assign out_src     = out_src_q;
    assign out_data    = out_data_q;
    assign out_crc_ok  = out_crc_ok_q;
    assign out_timeout = out_timeout_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sent_rx_crc_arbiter.sv
// Testbench for sent_rx_crc_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_sent_rx_crc_arbiter;

    localparam int TMO = 8;

    logic        clk_rx = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic [27:0] data_fast6;
    logic [19:0] data_fast4;
    logic [15:0] data_fast3;
    logic [15:0] data_short;
    logic [27:0] data_enhanced;
    logic        ovr_clr;
    logic        crc_start;
    logic [27:0] crc_data;
    logic [2:0]  crc_mode;
    logic        crc_done;
    logic        crc_ok;
    logic        out_valid;
    logic [2:0]  out_src;
    logic [27:0] out_data;
    logic        out_crc_ok;
    logic        out_timeout;
    logic [4:0]  overrun;
    logic        busy;

    sent_rx_crc_arbiter #(.TIMEOUT(TMO)) dut (
        .clk_rx(clk_rx), .reset(reset), .req(req),
        .data_fast6(data_fast6), .data_fast4(data_fast4), .data_fast3(data_fast3),
        .data_short(data_short), .data_enhanced(data_enhanced), .ovr_clr(ovr_clr),
        .crc_start(crc_start), .crc_data(crc_data), .crc_mode(crc_mode),
        .crc_done(crc_done), .crc_ok(crc_ok),
        .out_valid(out_valid), .out_src(out_src), .out_data(out_data),
        .out_crc_ok(out_crc_ok), .out_timeout(out_timeout),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk_rx = ~clk_rx;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    // Reference model: pending set, buffered words, sticky overruns, rr pointer,
    // and the single check in flight with its predicted result cycle.
    bit   [4:0]  m_pend;
    logic [27:0] m_word [5];
    bit   [4:0]  m_ovr;
    int          m_rr;
    bit          inflight;
    int          idle_from;
    int          exp_out_cyc;
    int          exp_src;
    logic [27:0] exp_data;
    bit          exp_ok;
    bit          exp_to;
    int          resp_cnt;

    // Checker emulation controls.
    bit resp_en  = 1'b1;
    int force_d  = 0;
    int force_ok = -1;

    // Logs for scenario checks.
    int          grant_log[$];
    int          start_cyc_log[$];
    int          out_cyc_log[$];
    int          res_src[$];
    logic [27:0] res_data[$];
    bit          res_ok[$];
    bit          res_to[$];

    bit   mon_exp_start;
    bit   mon_exp_ov;
    bit   [4:0] mon_newo;
    int   mon_idx;
    int   mon_d;
    logic [27:0] mon_w;

    task automatic clear_logs();
        grant_log.delete(); start_cyc_log.delete(); out_cyc_log.delete();
        res_src.delete(); res_data.delete(); res_ok.delete(); res_to.delete();
    endtask

    // Cycle monitor: emulates the checker and compares every output to the model.
    always @(posedge clk_rx) begin
        #1;
        cyc++;
        if (reset) begin
            m_pend = 5'd0; m_ovr = 5'd0; m_rr = 0; inflight = 1'b0;
            idle_from = cyc; resp_cnt = 0;
            if (resp_en) begin crc_done = 1'b0; crc_ok = 1'b0; end
        end else begin
            if (resp_en) begin
                crc_done = 1'b0;
                if (inflight && resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) crc_done = 1'b1;
                end
                crc_ok = crc_done ? exp_ok : 1'($urandom_range(0, 1));
            end
            mon_exp_start = !inflight && (cyc >= idle_from + 1) && (m_pend != 5'd0);
            total_cnt++;
            if (crc_start !== mon_exp_start) $display("FAIL start_timing cyc=%0d crc_start=%b expected %b", cyc, crc_start, mon_exp_start);
            else pass_cnt++;
            if (mon_exp_start) begin
                mon_idx = -1;
                for (int k = 0; k < 5; k++)
                    if (mon_idx < 0 && m_pend[(m_rr + k) % 5]) mon_idx = (m_rr + k) % 5;
                total_cnt++;
                if (crc_mode !== 3'(mon_idx) || crc_data !== m_word[mon_idx])
                    $display("FAIL grant_select cyc=%0d got mode=%0d data=%h expected mode=%0d data=%h", cyc, crc_mode, crc_data, mon_idx, m_word[mon_idx]);
                else pass_cnt++;
                m_pend[mon_idx] = 1'b0;
                m_rr = (mon_idx + 1) % 5;
                inflight = 1'b1;
                exp_src = mon_idx;
                exp_data = m_word[mon_idx];
                grant_log.push_back(mon_idx);
                start_cyc_log.push_back(cyc);
                if (resp_en) begin
                    mon_d = (force_d > 0) ? force_d : int'($urandom_range(1, 4));
                    resp_cnt = mon_d;
                    exp_out_cyc = cyc + 1 + mon_d;
                    exp_ok = (force_ok >= 0) ? (force_ok != 0) : ($urandom_range(0, 1) != 0);
                    exp_to = 1'b0;
                end else begin
                    exp_out_cyc = cyc + TMO + 2;
                    exp_ok = 1'b0;
                    exp_to = 1'b1;
                end
            end
            mon_exp_ov = inflight && (cyc == exp_out_cyc);
            total_cnt++;
            if (out_valid !== mon_exp_ov) $display("FAIL out_valid_timing cyc=%0d got %b expected %b", cyc, out_valid, mon_exp_ov);
            else pass_cnt++;
            if (mon_exp_ov) begin
                total_cnt++;
                if (out_src !== 3'(exp_src) || out_data !== exp_data || out_crc_ok !== exp_ok || out_timeout !== exp_to)
                    $display("FAIL result cyc=%0d got src=%0d data=%h ok=%b to=%b expected src=%0d data=%h ok=%b to=%b",
                             cyc, out_src, out_data, out_crc_ok, out_timeout, exp_src, exp_data, exp_ok, exp_to);
                else pass_cnt++;
                res_src.push_back(exp_src); res_data.push_back(exp_data);
                res_ok.push_back(exp_ok); res_to.push_back(exp_to);
                out_cyc_log.push_back(cyc);
                inflight = 1'b0;
                idle_from = cyc + 1;
            end
            total_cnt++;
            if (busy !== (inflight || mon_exp_ov)) $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, inflight || mon_exp_ov);
            else pass_cnt++;
            mon_newo = 5'd0;
            for (int i = 0; i < 5; i++) begin
                if (req[i]) begin
                    case (i)
                        0: mon_w = data_fast6;
                        1: mon_w = {8'd0, data_fast4};
                        2: mon_w = {12'd0, data_fast3};
                        3: mon_w = {12'd0, data_short};
                        default: mon_w = data_enhanced;
                    endcase
                    if (m_pend[i]) mon_newo[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    m_word[i] = mon_w;
                end
            end
            m_ovr = (ovr_clr ? 5'd0 : m_ovr) | mon_newo;
            total_cnt++;
            if (overrun !== m_ovr) $display("FAIL overrun cyc=%0d got %b expected %b", cyc, overrun, m_ovr);
            else pass_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk_rx);
        reset = 1'b1; req = 5'd0; ovr_clr = 1'b0;
        repeat (2) @(negedge clk_rx);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_rx);
        total_cnt++;
        if ({crc_start, crc_data, crc_mode} !== 32'd0) $display("FAIL reset_crc_side got %h expected 0", {crc_start, crc_data, crc_mode});
        else pass_cnt++;
        total_cnt++;
        if ({out_valid, out_src, out_data, out_crc_ok, out_timeout} !== 34'd0)
            $display("FAIL reset_out_side got %h expected 0", {out_valid, out_src, out_data, out_crc_ok, out_timeout});
        else pass_cnt++;
        total_cnt++;
        if ({overrun, busy} !== 6'd0) $display("FAIL reset_status got %b expected 0", {overrun, busy});
        else pass_cnt++;
        reset = 1'b0;
        repeat (4) @(negedge clk_rx);
        total_cnt++;
        if (busy !== 1'b0 || crc_start !== 1'b0) $display("FAIL reset_idle got busy=%b start=%b expected 0 0", busy, crc_start);
        else pass_cnt++;
    endtask

    task automatic test_single();
        int t;
        do_reset(); clear_logs(); force_d = 2; force_ok = 1;
        data_fast3 = 16'hA5C3; req = 5'b00100;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (crc_start !== 1'b1 && t < 20) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (crc_start !== 1'b1 || crc_data !== 28'h000A5C3 || crc_mode !== 3'd2)
            $display("FAIL single_grant got start=%b data=%h mode=%0d expected 1 000a5c3 2", crc_start, crc_data, crc_mode);
        else pass_cnt++;
        t = 0;
        while (res_src.size() < 1 && t < 20) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (res_src.size() != 1 || out_src !== 3'd2 || out_data !== 28'h000A5C3 || out_crc_ok !== 1'b1 || out_timeout !== 1'b0)
            $display("FAIL single_result got n=%0d src=%0d data=%h ok=%b to=%b expected 1 2 000a5c3 1 0",
                     res_src.size(), out_src, out_data, out_crc_ok, out_timeout);
        else pass_cnt++;
        repeat (3) @(negedge clk_rx);
        total_cnt++;
        if (crc_data !== 28'h000A5C3 || crc_mode !== 3'd2) $display("FAIL single_hold got %h/%0d expected 000a5c3/2", crc_data, crc_mode);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int t;
        do_reset(); clear_logs(); force_d = 1; force_ok = -1;
        data_fast6 = 28'($urandom); data_fast4 = 20'($urandom); data_fast3 = 16'($urandom);
        data_short = 16'($urandom); data_enhanced = 28'($urandom);
        req = 5'b11111;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (res_src.size() < 5 && t < 60) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (res_src.size() != 5) $display("FAIL simul_count got %0d expected 5", res_src.size());
        else pass_cnt++;
        for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
            total_cnt++;
            if (grant_log[i] != i) $display("FAIL simul_order slot %0d got %0d expected %0d", i, grant_log[i], i);
            else pass_cnt++;
        end
        total_cnt++;
        if (overrun !== 5'd0) $display("FAIL simul_overrun got %b expected 00000", overrun);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int t;
        do_reset(); clear_logs(); force_d = 3;
        req = 5'b01000;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin @(negedge clk_rx); t++; end
        req = 5'b10001;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (res_src.size() < 3 && t < 60) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (grant_log.size() != 3 || grant_log[0] != 3 || grant_log[1] != 4 || grant_log[2] != 0)
            $display("FAIL rr_order got n=%0d expected order 3,4,0", grant_log.size());
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        int t;
        logic [19:0] w2;
        do_reset(); clear_logs(); force_d = 6;
        req = 5'b00001;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin @(negedge clk_rx); t++; end
        data_fast4 = 20'h12345; req = 5'b00010;
        @(negedge clk_rx); req = 5'd0;
        @(negedge clk_rx);
        w2 = 20'($urandom) | 20'h1; data_fast4 = w2; req = 5'b00010;
        @(negedge clk_rx); req = 5'd0;
        @(negedge clk_rx);
        total_cnt++;
        if (overrun !== 5'b00010) $display("FAIL ovr_set got %b expected 00010", overrun);
        else pass_cnt++;
        t = 0;
        while (res_src.size() < 2 && t < 40) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (res_src.size() != 2 || res_src[1] != 1 || out_data !== {8'd0, w2})
            $display("FAIL ovr_word got n=%0d data=%h expected 2 %h", res_src.size(), out_data, {8'd0, w2});
        else pass_cnt++;
        ovr_clr = 1'b1;
        @(negedge clk_rx); ovr_clr = 1'b0;
        total_cnt++;
        if (overrun !== 5'd0) $display("FAIL ovr_clear got %b expected 00000", overrun);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int t;
        do_reset(); clear_logs(); resp_en = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
        data_short = 16'($urandom); req = 5'b01000;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (res_src.size() < 1 && t < 40) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (res_src.size() != 1 || out_crc_ok !== 1'b0 || out_timeout !== 1'b1)
            $display("FAIL timeout_result got n=%0d ok=%b to=%b expected 1 0 1", res_src.size(), out_crc_ok, out_timeout);
        else pass_cnt++;
        if (res_src.size() == 1) begin
            total_cnt++;
            if (out_cyc_log[0] - (start_cyc_log[0] + 1) != 9)
                $display("FAIL timeout_latency got %0d expected 9", out_cyc_log[0] - (start_cyc_log[0] + 1));
            else pass_cnt++;
        end
        crc_done = 1'b1; crc_ok = 1'b1;
        repeat (3) @(negedge clk_rx);
        crc_done = 1'b0; crc_ok = 1'b0;
        repeat (3) @(negedge clk_rx);
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL late_done got busy=%b ov=%b expected 0 0", busy, out_valid);
        else pass_cnt++;
        resp_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int t;
        do_reset(); clear_logs(); resp_en = 1'b0; crc_done = 1'b0;
        req = 5'b00001;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (grant_log.size() < 1 && t < 20) begin @(negedge clk_rx); t++; end
        req = 5'b00110;
        @(negedge clk_rx); req = 5'd0;
        @(negedge clk_rx);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({crc_start, crc_data, crc_mode, out_valid, out_src, out_data, out_crc_ok, out_timeout, overrun, busy} !== 72'd0)
            $display("FAIL midwait_reset_values got %h expected 0",
                     {crc_start, crc_data, crc_mode, out_valid, out_src, out_data, out_crc_ok, out_timeout, overrun, busy});
        else pass_cnt++;
        @(negedge clk_rx); reset = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_rx);
            total_cnt++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || crc_start !== 1'b0)
                $display("FAIL midwait_idle cycle %0d got ov=%b busy=%b start=%b expected 0 0 0", i, out_valid, busy, crc_start);
            else pass_cnt++;
        end
        data_enhanced = 28'($urandom); req = 5'b10000;
        @(negedge clk_rx); req = 5'd0;
        t = 0;
        while (res_src.size() < 1 && t < 20) begin @(negedge clk_rx); t++; end
        total_cnt++;
        if (res_src.size() != 1 || out_src !== 3'd4) $display("FAIL midwait_resume got n=%0d src=%0d expected 1 4", res_src.size(), out_src);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int t;
        int ov_seen;
        logic [4:0] r;
        do_reset(); clear_logs(); force_d = 0; force_ok = -1;
        ov_seen = 0;
        for (int c = 0; c < 600; c++) begin
            r = 5'd0;
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 9) == 0) r[i] = 1'b1;
            data_fast6 = 28'($urandom); data_fast4 = 20'($urandom); data_fast3 = 16'($urandom);
            data_short = 16'($urandom); data_enhanced = 28'($urandom);
            req = r;
            ovr_clr = ($urandom_range(0, 19) == 0);
            @(negedge clk_rx);
            if (out_valid === 1'b1) ov_seen++;
        end
        req = 5'd0; ovr_clr = 1'b0;
        t = 0;
        while ((m_pend != 5'd0 || inflight) && t < 300) begin
            @(negedge clk_rx);
            if (out_valid === 1'b1) ov_seen++;
            t++;
        end
        repeat (3) @(negedge clk_rx);
        total_cnt++;
        if (ov_seen != grant_log.size() || grant_log.size() == 0)
            $display("FAIL random_results got %0d out_valid pulses expected %0d", ov_seen, grant_log.size());
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; req = 5'd0; ovr_clr = 1'b0;
        data_fast6 = 28'd0; data_fast4 = 20'd0; data_fast3 = 16'd0;
        data_short = 16'd0; data_enhanced = 28'd0;
        crc_done = 1'b0; crc_ok = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
